// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory bus between the CPU fetch and data ports.
// Optional ARB_TIMEOUT_EN: abort a bus cycle after TIMEOUT_CYCLES wait states (Rev 1.0).
`default_nettype none

module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byteen,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic                mem_waitrequest,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_FETCH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                wr_q, wr_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic                if_err_q, if_err_d;
  logic                d_err_q, d_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wr_d       = wr_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    if_err_d   = 1'b0;
    d_err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // A requester being acked this cycle still shows its request; masking it avoids a re-issue.
        if ((d_read || d_write) && !d_ack_q) begin
          addr_d  = d_addr;
          wdata_d = d_wdata;
          be_d    = d_byteen;
          wr_d    = d_write;
          state_d = S_DATA;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (if_req && !if_ack_q) begin
          addr_d  = if_addr;
          be_d    = '1;
          wr_d    = 1'b0;
          state_d = S_FETCH;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_DATA, S_FETCH: begin
        if (!mem_waitrequest) begin
          state_d = S_IDLE;
          if (state_q == S_FETCH) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_readdata;
          end else begin
            d_ack_d = 1'b1;
            if (!wr_q) d_rdata_d = mem_readdata;
          end
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // This edge is the TIMEOUT_CYCLES-th wait state: abort, rdata left untouched.
          state_d = S_IDLE;
          if (state_q == S_FETCH) begin
            if_ack_d = 1'b1;
            if_err_d = 1'b1;
          end else begin
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wr_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= '0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wr_q       <= wr_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      if_err_q   <= if_err_d;
      d_err_q    <= d_err_d;
`endif
    end
  end

  // Strobes decode straight from the state register so a reset drops them at once.
  assign mem_read       = (state_q == S_FETCH) || ((state_q == S_DATA) && !wr_q);
  assign mem_write      = (state_q == S_DATA) && wr_q;
  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign busy           = (state_q != S_IDLE);
  assign if_ack         = if_ack_q;
  assign d_ack          = d_ack_q;
  assign if_rdata       = if_rdata_q;
  assign d_rdata        = d_rdata_q;

`ifdef ARB_TIMEOUT_EN
  assign if_err = if_err_q;
  assign d_err  = d_err_q;
`else
  assign if_err = 1'b0;
  assign d_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the CPU instruction-fetch port and the data (load/store) port, for the bus-interface variant of the MIPS CPU.
- Sits between the CPU core's fetch/data request ports and the external memory bus.
- Sequences one bus transaction at a time with a 3-state FSM, holds bus signals stable across wait states and returns registered read data with a one-cycle acknowledge per requester.

Parameters:
ADDR_W, 32, address width of both requesters and the bus
DATA_W, 32, data width; byteenable width is DATA_W/8
TIMEOUT_CYCLES, 255, wait-state limit before abort; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low (0 = reset); clears all state immediately
if_req  in  1  fetch request; held high with if_addr until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid
if_rdata  out  DATA_W  fetched word, held until the next fetch completes
if_err  out  1  valid with if_ack; fetch aborted by timeout
d_read  in  1  data read request
d_write  in  1  data write request
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_byteen  in  DATA_W/8  store/load byte enables
d_ack  out  1  one-cycle pulse: data access done
d_rdata  out  DATA_W  load word, held until the next data read completes
d_err  out  1  valid with d_ack; access aborted by timeout
mem_address  out  ADDR_W  bus address
mem_read  out  1  bus read strobe
mem_write  out  1  bus write strobe
mem_writedata  out  DATA_W  bus write data
mem_byteenable  out  DATA_W/8  bus byte enables
mem_waitrequest  in  1  slave stall; transfer completes on an edge where this is 0
mem_readdata  in  DATA_W  bus read data, sampled at completion
busy  out  1  high while state is not IDLE

Behaviour:
- Reset: state=IDLE. All outputs are 0 (mem_*, acks, errs, rdata regs, busy). Reset taken mid-transaction drops the strobes immediately; no ack is issued for the killed transaction.
- States:
  - IDLE: bus strobes 0; mem_address, mem_writedata and mem_byteenable hold their last values.
  - DATA: drives the data request onto the bus.
  - FETCH: drives the fetch request onto the bus; mem_read=1, mem_byteenable=all ones.
- IDLE arbitration, evaluated on each edge:
  - Data requests (d_read|d_write) have fixed priority over if_req. Data is always the older instruction, and the core stalls fetch meanwhile.
  - A requester whose ack is high in the current cycle is ignored. Its req may still be high that cycle, and this prevents a double issue.
  - The selected request's address, data and byteenable are latched into bus registers; next state is DATA or FETCH.
- d_read and d_write both high is a protocol violation: it is handled as a write, and no read is issued.
- Bus cycle: strobes and address are registered and stable while mem_waitrequest=1. On an edge with mem_waitrequest=0:
  - the transfer completes;
  - for a read, mem_readdata is captured into if_rdata or d_rdata;
  - the matching ack is high for exactly the next cycle;
  - state returns to IDLE with strobes deasserted in that same cycle.
- d_rdata is not updated by writes. d_ack is issued for writes as well.
- Latency, request high to ack: 2 cycles with zero wait states, plus N cycles for N wait states. Back-to-back throughput is one transfer per 2 cycles minimum.
- Inputs are sampled only in IDLE. Changes on the request inputs during DATA or FETCH are ignored.
- Simultaneous if_req and data request in IDLE: DATA first. FETCH is granted in the IDLE cycle after d_ack if if_req is still high.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-or-more-bit counter clears on entry to DATA or FETCH and increments on each edge with mem_waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES with waitrequest still 1, the FSM aborts: strobes drop and state goes to IDLE.
  - The matching ack is asserted with err=1; the rdata register is unchanged.
- Not defined: no counter is built; if_err and d_err are tied to 0; the FSM waits indefinitely.

Test Plan:
1. Fetch, zero waits: if_req=1, if_addr=0xBFC00000, mem_readdata=0x24020005 -> mem_read high for 1 cycle at 0xBFC00000; if_ack pulses 2 cycles after request; if_rdata=0x24020005; if_err=0.
2. Store, 3 waits: d_write=1, d_addr=0x00001000, d_wdata=0xDEADBEEF, d_byteen=0xF -> mem_write/address/data stable for 4 cycles; d_ack 1 cycle after the waitrequest drop; d_rdata unchanged.
3. Contention: if_req and d_read rise in the same cycle (d_addr=0x10, readdata 0x11111111, then fetch 0x22222222) -> bus order DATA then FETCH; d_ack before if_ack; rdata values routed to the correct ports.
4. Reset mid-wait: assert reset low during a FETCH with waitrequest=1 -> mem_read=0 immediately, no if_ack; after release, busy=0 and all outputs are 0.
5. Illegal request: d_read=d_write=1, d_addr=0x20 -> a single write cycle; mem_read never high; d_ack once.
6. Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4), waitrequest stuck at 1 on a fetch -> strobe drops after 4 wait edges; if_ack=1 with if_err=1; if_rdata retains its previous value.
